// File: rtl/stopwatch_ctrl_if.sv
// Signals between the stopwatch controller and the board: debounced buttons,
// the live BCD count, counter control pulses and the multiplexed digit drive.
interface stopwatch_ctrl_if;
    logic       btn_start;
    logic       btn_clear;
    logic       btn_lap;
    logic [7:0] bcd_in;
    logic       cnt_en;
    logic       cnt_clr_n;
    logic       running;
    logic       lap_hold;
    logic [3:0] disp_bcd;
    logic [1:0] digit_sel;
    logic [1:0] state_dbg;

    // No valid/ready pairs here: buttons are active-low levels sampled every clk,
    // cnt_en / cnt_clr_n are single-cycle registered pulses, the rest are registered levels.
    modport master (
        output btn_start, btn_clear, btn_lap, bcd_in,
        input  cnt_en, cnt_clr_n, running, lap_hold, disp_bcd, digit_sel, state_dbg
    );

    modport slave (
        input  btn_start, btn_clear, btn_lap, bcd_in,
        output cnt_en, cnt_clr_n, running, lap_hold, disp_bcd, digit_sel, state_dbg
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: button edge detection, idle/run/pause FSM, count tick
// prescaler, lap snapshot and two-digit display multiplexing.
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned SCAN_DIV = 1000
) (
    input logic             clk,
    input logic             n_reset,
    stopwatch_ctrl_if.slave sw
);
    localparam int unsigned PW  = $clog2(TICK_DIV);
    localparam int unsigned SCW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]  PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t         state;
    logic [2:0]     sync1;
    logic [2:0]     sync2;
    logic [2:0]     edge_q;
    logic [2:0]     press;
    logic           start_ev;
    logic           clr_ev;
    logic           lap_ev;
    logic [PW-1:0]  presc;
    logic           pre_term;
    logic [7:0]     lap_reg;
    logic           cnt_en_q;
    logic           cnt_clr_n_q;
    logic           running_q;
    logic           lap_hold_q;
    logic [SCW-1:0] scan_cnt;
    logic           digit_idx;
    logic [3:0]     disp_bcd_q;
    logic [1:0]     digit_sel_q;
    logic [7:0]     shown;

    // Bit order in all button vectors: [2]=lap, [1]=clear, [0]=start.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sync1  <= 3'b111;
            sync2  <= 3'b111;
            edge_q <= 3'b111;
        end else begin
            sync1  <= {sw.btn_lap, sw.btn_clear, sw.btn_start};
            sync2  <= sync1;
            edge_q <= sync2;
        end
    end

    assign press    = ~sync2 & edge_q;
    assign start_ev = press[0];
    assign clr_ev   = press[1];
    assign lap_ev   = press[2];
    assign pre_term = (presc == PRE_LAST);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state       <= ST_IDLE;
            running_q   <= 1'b0;
            cnt_en_q    <= 1'b0;
            cnt_clr_n_q <= 1'b1;
            lap_hold_q  <= 1'b0;
            lap_reg     <= 8'h00;
            presc       <= '0;
        end else begin
            cnt_en_q    <= 1'b0;
            cnt_clr_n_q <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (clr_ev) begin
                        cnt_clr_n_q <= 1'b0;
                    end else if (start_ev) begin
                        state     <= ST_RUN;
                        running_q <= 1'b1;
                        presc     <= '0;
                    end
                end
                ST_RUN: begin
                    // The tick divider keeps stepping on the cycle a pause is taken;
                    // only the pulse itself is dropped.
                    if (pre_term) begin
                        presc <= '0;
                    end else begin
                        presc <= presc + PW'(1);
                    end
                    if (start_ev) begin
                        state     <= ST_PAUSE;
                        running_q <= 1'b0;
                    end else begin
                        cnt_en_q <= pre_term;
                        if (lap_ev) begin
                            lap_hold_q <= ~lap_hold_q;
                            if (!lap_hold_q) begin
                                lap_reg <= sw.bcd_in;
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    if (clr_ev) begin
                        state       <= ST_IDLE;
                        running_q   <= 1'b0;
                        cnt_clr_n_q <= 1'b0;
                        lap_hold_q  <= 1'b0;
                    end else if (start_ev) begin
                        state     <= ST_RUN;
                        running_q <= 1'b1;
                    end else if (lap_ev && lap_hold_q) begin
                        lap_hold_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign shown = lap_hold_q ? lap_reg : sw.bcd_in;

    // Scan runs in every state so the display never freezes on one digit.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            scan_cnt    <= '0;
            digit_idx   <= 1'b0;
            disp_bcd_q  <= 4'h0;
            digit_sel_q <= 2'b10;
        end else begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt  <= '0;
                digit_idx <= ~digit_idx;
            end else begin
                scan_cnt <= scan_cnt + SCW'(1);
            end
            if (digit_idx) begin
                disp_bcd_q  <= shown[7:4];
                digit_sel_q <= 2'b01;
            end else begin
                disp_bcd_q  <= shown[3:0];
                digit_sel_q <= 2'b10;
            end
        end
    end

    assign sw.cnt_en    = cnt_en_q;
    assign sw.cnt_clr_n = cnt_clr_n_q;
    assign sw.running   = running_q;
    assign sw.lap_hold  = lap_hold_q;
    assign sw.disp_bcd  = disp_bcd_q;
    assign sw.digit_sel = digit_sel_q;
    assign sw.state_dbg = state;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a small BCD counter model on cnt_en / cnt_clr_n.
module tb_stopwatch_ctrl;
    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       ld = 1'b0;
    logic [7:0] ld_val = 8'h00;
    logic [7:0] cnt_model = 8'h00;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    logic [0:0] exp_q[$];

    stopwatch_ctrl_if sw_if ();

    stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .sw      (sw_if)
    );

    // ---------------- clock / reset / counter model ----------------
    always #5 clk = ~clk;

    assign sw_if.bcd_in = cnt_model;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] t;
        logic [3:0] u;
        t = v[7:4];
        u = v[3:0];
        if (u == 4'd9) begin
            u = 4'd0;
            t = (t == 4'd9) ? 4'd0 : t + 4'd1;
        end else begin
            u = u + 4'd1;
        end
        return {t, u};
    endfunction

    always @(posedge clk) begin
        if (ld) cnt_model <= ld_val;
        else if (!n_reset || !sw_if.cnt_clr_n) cnt_model <= 8'h00;
        else if (sw_if.cnt_en) cnt_model <= bcd_inc(cnt_model);
    end

    // Rising edges since reset release; sets the expected digit phase.
    always @(posedge clk) begin
        if (!n_reset) cyc <= 0;
        else cyc <= cyc + 1;
    end

    function automatic logic [1:0] exp_sel_f(input int k);
        return ((((k - 1) / SCAN_DIV) % 2) == 1) ? 2'b01 : 2'b10;
    endfunction

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        n_reset = 1'b0;
        sw_if.btn_start = 1'b1;
        sw_if.btn_clear = 1'b1;
        sw_if.btn_lap = 1'b1;
        @(negedge clk);
        ld = 1'b1;
        ld_val = 8'h59;
        @(negedge clk);
        ld = 1'b0;
        checks++; if (sw_if.cnt_en !== 1'b0) begin errors++; $display("FAIL reset cnt_en: got %0b expected 0", sw_if.cnt_en); end
        checks++; if (sw_if.cnt_clr_n !== 1'b1) begin errors++; $display("FAIL reset cnt_clr_n: got %0b expected 1", sw_if.cnt_clr_n); end
        checks++; if (sw_if.running !== 1'b0) begin errors++; $display("FAIL reset running: got %0b expected 0", sw_if.running); end
        checks++; if (sw_if.lap_hold !== 1'b0) begin errors++; $display("FAIL reset lap_hold: got %0b expected 0", sw_if.lap_hold); end
        checks++; if (sw_if.disp_bcd !== 4'h0) begin errors++; $display("FAIL reset disp_bcd: got %0h expected 0", sw_if.disp_bcd); end
        checks++; if (sw_if.digit_sel !== 2'b10) begin errors++; $display("FAIL reset digit_sel: got %b expected 10", sw_if.digit_sel); end
        checks++; if (sw_if.state_dbg !== 2'd0) begin errors++; $display("FAIL reset state: got %0d expected 0", sw_if.state_dbg); end
        n_reset = 1'b1;
    endtask

    task automatic test_idle_scan();
        logic [1:0] es;
        logic [3:0] ed;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            es = exp_sel_f(cyc);
            ed = (es == 2'b10) ? 4'h9 : 4'h5;
            checks++; if (sw_if.digit_sel !== es) begin errors++; $display("FAIL idle_scan digit_sel k=%0d: got %b expected %b", k, sw_if.digit_sel, es); end
            checks++; if (sw_if.disp_bcd !== ed) begin errors++; $display("FAIL idle_scan disp_bcd k=%0d: got %0h expected %0h", k, sw_if.disp_bcd, ed); end
            checks++; if (sw_if.cnt_en !== 1'b0) begin errors++; $display("FAIL idle_scan cnt_en k=%0d: got %0b expected 0", k, sw_if.cnt_en); end
        end
    endtask

    task automatic test_start_run();
        ld = 1'b1;
        ld_val = 8'h00;
        @(negedge clk);
        ld = 1'b0;
        sw_if.btn_start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++; if (sw_if.running !== 1'b0) begin errors++; $display("FAIL start early running: got %0b expected 0", sw_if.running); end
        end
        @(negedge clk);
        checks++; if (sw_if.running !== 1'b1) begin errors++; $display("FAIL start running: got %0b expected 1", sw_if.running); end
        checks++; if (sw_if.state_dbg !== 2'd1) begin errors++; $display("FAIL start state: got %0d expected 1", sw_if.state_dbg); end
        for (int i = 0; i < 40; i++) exp_q.push_back((i % 4 == 3) ? 1'b1 : 1'b0);
        for (int i = 0; i < 40; i++) begin
            logic [0:0] e;
            @(negedge clk);
            if (i == 1) sw_if.btn_start = 1'b1;
            e = exp_q.pop_front();
            checks++; if (sw_if.cnt_en !== e) begin errors++; $display("FAIL run cnt_en i=%0d: got %0b expected %0b", i, sw_if.cnt_en, e); end
        end
        @(negedge clk);
        checks++; if (sw_if.bcd_in !== 8'h10) begin errors++; $display("FAIL run count: got %0h expected 10", sw_if.bcd_in); end
    endtask

    task automatic test_pause_resume();
        @(negedge clk);
        checks++; if (sw_if.cnt_en !== 1'b0) begin errors++; $display("FAIL pause pre cnt_en: got %0b expected 0", sw_if.cnt_en); end
        sw_if.btn_start = 1'b0;
        @(negedge clk);
        checks++; if (sw_if.cnt_en !== 1'b0) begin errors++; $display("FAIL pause e1 cnt_en: got %0b expected 0", sw_if.cnt_en); end
        @(negedge clk);
        checks++; if (sw_if.cnt_en !== 1'b1) begin errors++; $display("FAIL pause e2 cnt_en: got %0b expected 1", sw_if.cnt_en); end
        checks++; if (sw_if.running !== 1'b1) begin errors++; $display("FAIL pause e2 running: got %0b expected 1", sw_if.running); end
        @(negedge clk);
        checks++; if (sw_if.running !== 1'b0) begin errors++; $display("FAIL pause running: got %0b expected 0", sw_if.running); end
        checks++; if (sw_if.state_dbg !== 2'd2) begin errors++; $display("FAIL pause state: got %0d expected 2", sw_if.state_dbg); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) sw_if.btn_start = 1'b1;
            checks++; if (sw_if.cnt_en !== 1'b0) begin errors++; $display("FAIL paused cnt_en i=%0d: got %0b expected 0", i, sw_if.cnt_en); end
        end
        // Resume: prescaler held at 1, so the tick arrives 3 cycles after running rises.
        sw_if.btn_start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (sw_if.running !== 1'b1) begin errors++; $display("FAIL resume running: got %0b expected 1", sw_if.running); end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (i == 1) sw_if.btn_start = 1'b1;
            checks++; if (sw_if.cnt_en !== (i == 3)) begin errors++; $display("FAIL resume cnt_en i=%0d: got %0b expected %0b", i, sw_if.cnt_en, (i == 3)); end
        end
        // Pause landing exactly on the terminal prescaler cycle drops that tick.
        @(negedge clk);
        sw_if.btn_start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checks++; if (sw_if.cnt_en !== 1'b0) begin errors++; $display("FAIL suppress cnt_en i=%0d: got %0b expected 0", i, sw_if.cnt_en); end
        end
        sw_if.btn_start = 1'b1;
        checks++; if (sw_if.running !== 1'b0) begin errors++; $display("FAIL suppress running: got %0b expected 0", sw_if.running); end
    endtask

    task automatic test_lap();
        logic [1:0] es;
        logic [3:0] ed;
        logic [7:0] v_prev;
        // Lap in PAUSE with nothing held is ignored.
        sw_if.btn_lap = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (sw_if.lap_hold !== 1'b0) begin errors++; $display("FAIL lap paused lap_hold: got %0b expected 0", sw_if.lap_hold); end
        @(negedge clk);
        sw_if.btn_lap = 1'b1;
        sw_if.btn_start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (sw_if.running !== 1'b1) begin errors++; $display("FAIL lap resume running: got %0b expected 1", sw_if.running); end
        @(negedge clk);
        sw_if.btn_start = 1'b1;
        sw_if.btn_lap = 1'b0;
        @(negedge clk);
        ld = 1'b1;
        ld_val = 8'h37;
        @(negedge clk);
        ld = 1'b0;
        checks++; if (sw_if.lap_hold !== 1'b0) begin errors++; $display("FAIL lap early lap_hold: got %0b expected 0", sw_if.lap_hold); end
        @(negedge clk);
        checks++; if (sw_if.lap_hold !== 1'b1) begin errors++; $display("FAIL lap lap_hold: got %0b expected 1", sw_if.lap_hold); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) begin ld = 1'b1; ld_val = 8'h64; end
            if (i == 1) begin ld = 1'b0; sw_if.btn_lap = 1'b1; end
            es = exp_sel_f(cyc);
            ed = (es == 2'b01) ? 4'h3 : 4'h7;
            checks++; if (sw_if.digit_sel !== es) begin errors++; $display("FAIL lap frozen digit_sel i=%0d: got %b expected %b", i, sw_if.digit_sel, es); end
            checks++; if (sw_if.disp_bcd !== ed) begin errors++; $display("FAIL lap frozen disp_bcd i=%0d: got %0h expected %0h", i, sw_if.disp_bcd, ed); end
        end
        sw_if.btn_lap = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (sw_if.lap_hold !== 1'b1) begin errors++; $display("FAIL unlap early lap_hold: got %0b expected 1", sw_if.lap_hold); end
        @(negedge clk);
        checks++; if (sw_if.lap_hold !== 1'b0) begin errors++; $display("FAIL unlap lap_hold: got %0b expected 0", sw_if.lap_hold); end
        v_prev = sw_if.bcd_in;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 1) sw_if.btn_lap = 1'b1;
            es = exp_sel_f(cyc);
            ed = (es == 2'b01) ? v_prev[7:4] : v_prev[3:0];
            checks++; if (sw_if.disp_bcd !== ed) begin errors++; $display("FAIL live disp_bcd i=%0d: got %0h expected %0h", i, sw_if.disp_bcd, ed); end
            v_prev = sw_if.bcd_in;
        end
    endtask

    task automatic test_clear();
        sw_if.btn_clear = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 4) sw_if.btn_clear = 1'b1;
            checks++; if (sw_if.cnt_clr_n !== 1'b1) begin errors++; $display("FAIL run clear cnt_clr_n i=%0d: got %0b expected 1", i, sw_if.cnt_clr_n); end
            checks++; if (sw_if.state_dbg !== 2'd1) begin errors++; $display("FAIL run clear state i=%0d: got %0d expected 1", i, sw_if.state_dbg); end
        end
        sw_if.btn_lap = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (sw_if.lap_hold !== 1'b1) begin errors++; $display("FAIL clear setup lap_hold: got %0b expected 1", sw_if.lap_hold); end
        @(negedge clk);
        sw_if.btn_lap = 1'b1;
        sw_if.btn_start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (sw_if.state_dbg !== 2'd2) begin errors++; $display("FAIL clear setup state: got %0d expected 2", sw_if.state_dbg); end
        @(negedge clk);
        sw_if.btn_start = 1'b1;
        @(negedge clk);
        sw_if.btn_start = 1'b0;
        sw_if.btn_clear = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++; if (sw_if.cnt_clr_n !== 1'b1) begin errors++; $display("FAIL pause clear early cnt_clr_n: got %0b expected 1", sw_if.cnt_clr_n); end
        end
        @(negedge clk);
        checks++; if (sw_if.cnt_clr_n !== 1'b0) begin errors++; $display("FAIL pause clear cnt_clr_n: got %0b expected 0", sw_if.cnt_clr_n); end
        checks++; if (sw_if.state_dbg !== 2'd0) begin errors++; $display("FAIL pause clear state: got %0d expected 0", sw_if.state_dbg); end
        checks++; if (sw_if.running !== 1'b0) begin errors++; $display("FAIL pause clear running: got %0b expected 0", sw_if.running); end
        checks++; if (sw_if.lap_hold !== 1'b0) begin errors++; $display("FAIL pause clear lap_hold: got %0b expected 0", sw_if.lap_hold); end
        @(negedge clk);
        checks++; if (sw_if.cnt_clr_n !== 1'b1) begin errors++; $display("FAIL pause clear width cnt_clr_n: got %0b expected 1", sw_if.cnt_clr_n); end
        checks++; if (sw_if.bcd_in !== 8'h00) begin errors++; $display("FAIL pause clear count: got %0h expected 00", sw_if.bcd_in); end
        sw_if.btn_start = 1'b1;
        sw_if.btn_clear = 1'b1;
        repeat (2) @(negedge clk);
        sw_if.btn_clear = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (sw_if.cnt_clr_n !== 1'b0) begin errors++; $display("FAIL idle clear cnt_clr_n: got %0b expected 0", sw_if.cnt_clr_n); end
        checks++; if (sw_if.state_dbg !== 2'd0) begin errors++; $display("FAIL idle clear state: got %0d expected 0", sw_if.state_dbg); end
        @(negedge clk);
        sw_if.btn_clear = 1'b1;
        checks++; if (sw_if.cnt_clr_n !== 1'b1) begin errors++; $display("FAIL idle clear width cnt_clr_n: got %0b expected 1", sw_if.cnt_clr_n); end
    endtask

    task automatic test_reset_mid_run();
        sw_if.btn_start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (sw_if.running !== 1'b1) begin errors++; $display("FAIL mid reset setup running: got %0b expected 1", sw_if.running); end
        @(negedge clk);
        sw_if.btn_start = 1'b1;
        sw_if.btn_lap = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (sw_if.lap_hold !== 1'b1) begin errors++; $display("FAIL mid reset setup lap_hold: got %0b expected 1", sw_if.lap_hold); end
        @(negedge clk);
        sw_if.btn_lap = 1'b1;
        #2;
        n_reset = 1'b0;
        #1;
        checks++; if (sw_if.running !== 1'b0) begin errors++; $display("FAIL mid reset running: got %0b expected 0", sw_if.running); end
        checks++; if (sw_if.lap_hold !== 1'b0) begin errors++; $display("FAIL mid reset lap_hold: got %0b expected 0", sw_if.lap_hold); end
        checks++; if (sw_if.cnt_en !== 1'b0) begin errors++; $display("FAIL mid reset cnt_en: got %0b expected 0", sw_if.cnt_en); end
        checks++; if (sw_if.cnt_clr_n !== 1'b1) begin errors++; $display("FAIL mid reset cnt_clr_n: got %0b expected 1", sw_if.cnt_clr_n); end
        checks++; if (sw_if.disp_bcd !== 4'h0) begin errors++; $display("FAIL mid reset disp_bcd: got %0h expected 0", sw_if.disp_bcd); end
        checks++; if (sw_if.digit_sel !== 2'b10) begin errors++; $display("FAIL mid reset digit_sel: got %b expected 10", sw_if.digit_sel); end
        checks++; if (sw_if.state_dbg !== 2'd0) begin errors++; $display("FAIL mid reset state: got %0d expected 0", sw_if.state_dbg); end
        @(negedge clk);
        n_reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++; if (sw_if.cnt_en !== 1'b0) begin errors++; $display("FAIL post reset cnt_en i=%0d: got %0b expected 0", i, sw_if.cnt_en); end
            checks++; if (sw_if.state_dbg !== 2'd0) begin errors++; $display("FAIL post reset state i=%0d: got %0d expected 0", i, sw_if.state_dbg); end
            checks++; if (sw_if.digit_sel !== exp_sel_f(cyc)) begin errors++; $display("FAIL post reset digit_sel i=%0d: got %b expected %b", i, sw_if.digit_sel, exp_sel_f(cyc)); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_idle_scan();
        test_start_run();
        test_pause_resume();
        test_lap();
        test_clear();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
